// File: rtl/b200_spi_master.sv
// b200_spi_master: settings-bus SPI master driving the shared B2x0 sclk/mosi/sen bus.
// Define B200_SPI_MISO_CAPTURE_EN to build the MISO synchronizer and readback capture.
module b200_spi_master #(
  parameter logic [7:0] BASE = 8'd8,
  parameter int NUM_SEN = 8,
  parameter int CLKDIV_W = 16
) (
  input  logic                bus_clk,
  input  logic                reset_global,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  output logic                ready,
  output logic                done,
  output logic [31:0]         readback,
  output logic [NUM_SEN-1:0]  sen,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso
);
  typedef enum logic [2:0] {IDLE, ASSERT, SHIFT, DEASSERT, DONE} state_t;
  state_t state;
  logic [CLKDIV_W-1:0] clkdiv, div, cnt;
  logic [NUM_SEN-1:0] mask;
  logic [5:0] nbits, last, ecnt;
  logic [6:0] two_n;
  logic mosi_edge, miso_edge, mosi_edge_w, miso_edge_w;
  logic [31:0] sh;
  logic trig, half_end, final_edge;
  assign trig = set_stb && set_addr == BASE + 8'd2 && ready;
  assign half_end = cnt == div;
  assign final_edge = ecnt == last;
  assign two_n = (nbits == 6'd0 || nbits > 6'd32) ? 7'd64 : {nbits, 1'b0};
  always_ff @(posedge bus_clk or posedge reset_global)
    if (reset_global) begin
      state <= IDLE;
      clkdiv <= '0;
      div <= '0;
      cnt <= '0;
      mask <= '0;
      nbits <= '0;
      last <= '0;
      ecnt <= '0;
      mosi_edge <= 1'b0;
      miso_edge <= 1'b0;
      mosi_edge_w <= 1'b0;
      miso_edge_w <= 1'b0;
      sh <= '0;
      ready <= 1'b1;
      done <= 1'b0;
      sen <= '1;
      sclk <= 1'b0;
      mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt <= half_end ? '0 : cnt + CLKDIV_W'(1);
      if (set_stb && set_addr == BASE) clkdiv <= set_data[CLKDIV_W-1:0];
      if (set_stb && set_addr == BASE + 8'd1) begin
        mask <= set_data[NUM_SEN-1:0];
        nbits <= set_data[21:16];
        mosi_edge <= set_data[24];
        miso_edge <= set_data[25];
      end
      case (state)
        IDLE, DONE:
          if (trig) begin
            state <= ASSERT;
            ready <= 1'b0;
            div <= clkdiv;
            cnt <= '0;
            ecnt <= '0;
            last <= 6'(two_n - 7'd1);
            mosi_edge_w <= mosi_edge;
            miso_edge_w <= miso_edge;
            sen <= ~mask;
            mosi <= set_data[31];
            sh <= {set_data[30:0], 1'b0};
          end else state <= IDLE;
        ASSERT: if (half_end) state <= SHIFT;
        SHIFT:
          if (half_end) begin
            sclk <= ~sclk;
            ecnt <= ecnt + 6'd1;
            if (final_edge) state <= DEASSERT;
            else if (sclk ^ mosi_edge_w) begin
              mosi <= sh[31];
              sh <= {sh[30:0], 1'b0};
            end
          end
        DEASSERT:
          if (half_end) begin
            state <= DONE;
            done <= 1'b1;
            ready <= 1'b1;
            sen <= '1;
            mosi <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef B200_SPI_MISO_CAPTURE_EN
  // sp delays the sample edge by the two synchronizer stages
  logic m1, m2;
  logic [1:0] sp;
  logic [31:0] cap;
  always_ff @(posedge bus_clk or posedge reset_global)
    if (reset_global) begin
      m1 <= 1'b0;
      m2 <= 1'b0;
      sp <= '0;
      cap <= '0;
      readback <= '0;
    end else begin
      m1 <= miso;
      m2 <= m1;
      sp <= {sp[0], state == SHIFT && half_end && !(sclk ^ miso_edge_w)};
      if (trig) cap <= '0;
      else if (sp[1]) cap <= {cap[30:0], m2};
      if (state == DEASSERT && half_end) readback <= cap;
    end
`else
  logic unused_miso;
  assign unused_miso = miso ^ miso_edge_w;
  assign readback = '0;
`endif
endmodule

// File: tb/tb_b200_spi_master.sv
// tb_b200_spi_master: randomized self-checking bench with a transfer-level reference model
// and a behavioural MISO slave.
module tb_b200_spi_master;
  localparam logic [7:0] BASE = 8'd8;
  logic bus_clk = 0, reset_global = 1, set_stb = 0, miso = 0;
  logic [7:0] set_addr = '0;
  logic [31:0] set_data = '0;
  logic ready, done, sclk, mosi;
  logic [31:0] readback;
  logic [7:0] sen;
  int total = 0, bad = 0;
  int s_idx = 0, s_n = 32;
  logic [31:0] s_word = '0;
  logic s_lvl = 1'b1;

  always #5 bus_clk = ~bus_clk;

  b200_spi_master dut (
    .bus_clk(bus_clk), .reset_global(reset_global), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .ready(ready), .done(done), .readback(readback), .sen(sen),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  function automatic logic sbit(int j);
    return (j < s_n) ? s_word[s_n-1-j] : 1'b0;
  endfunction

  // slave: advances on the edge opposite the master's sample edge
  always @(sclk)
    if (sclk === s_lvl) s_idx++;
    else miso = sbit(s_idx);

  function automatic int neff(int nb);
    return (nb == 0 || nb > 32) ? 32 : nb;
  endfunction

  function automatic logic [31:0] rbx(logic [31:0] sw, int n);
`ifdef B200_SPI_MISO_CAPTURE_EN
    logic [31:0] one = 32'd1;
    return sw & ((one << n) - 32'd1);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] topmask(int n);
    logic [31:0] ones = '1;
    return ~(ones >> n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v, input bit now);
    if (!now) @(negedge bus_clk);
    set_stb = 1;
    set_addr = a;
    set_data = v;
  endtask

  task automatic slave(input logic [31:0] sw, input int nb, input bit mi);
    s_word = sw;
    s_n = neff(nb);
    s_lvl = !mi;
    s_idx = 0;
    miso = sbit(0);
  endtask

  task automatic setup(input int div, input logic [7:0] msk, input int nb, input bit mo,
                       input bit mi, input logic [31:0] sw);
    logic [5:0] nf;
    nf = nb[5:0];
    wr(BASE, div, 0);
    wr(BASE + 8'd1, {6'd0, mi, mo, 2'd0, nf, 8'd0, msk}, 0);
    slave(sw, nb, mi);
  endtask

  // follows one transfer from the trigger cycle until done, a timeout or a planted reset
  task automatic watch(input int n, input int h, input logic [7:0] msk, input logic [31:0] d,
                       input logic [31:0] rb_exp, input int busy_at, input int rst_rise);
    int k, rises, lim, senbad, dcnt;
    logic psclk, pmosi;
    logic [31:0] mw;
    bit dn;
    k = 0; rises = 0; senbad = 0; psclk = 0; pmosi = 0; mw = '0; dn = 0;
    lim = (2 * n + 2) * h + 30;
    while (!dn && k < lim) begin
      @(negedge bus_clk);
      k++;
      if (sclk && !psclk) begin
        if (rises < 32) mw[31-rises] = pmosi;
        rises++;
      end
      psclk = sclk;
      pmosi = mosi;
      if (k == 1) chk("ready_fall", ready, 1'b0);
      dn = (done === 1'b1);
      if (!dn && sen !== ~msk) senbad++;
      if (k == busy_at) begin
        set_stb = 1; set_addr = BASE + 8'd2; set_data = '1;
      end else set_stb = 0;
      if (rst_rise > 0 && rises == rst_rise) begin
        reset_global = 1;
        #2 reset_global = 0;
        @(negedge bus_clk);
        chk("rst_sen", sen, 8'hFF);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        dcnt = 0;
        repeat ((2 * n + 2) * h + 10) begin
          @(negedge bus_clk);
          if (done !== 1'b0) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);
        return;
      end
    end
    chk("done_time", dn ? k : 0, (2 * n + 2) * h + 1);
    chk("sclk_rises", rises, n);
    chk("mosi_bits", mw, d & topmask(n));
    chk("sen_hold", senbad, 0);
    chk("sen_done", sen, 8'hFF);
    chk("ready_done", ready, 1'b1);
    chk("readback", readback, rb_exp);
  endtask

  task automatic run(input int div, input logic [7:0] msk, input int nb, input bit mo, input bit mi,
                     input logic [31:0] d, input logic [31:0] sw, input int busy_at, input int rst_rise);
    setup(div, msk, nb, mo, mi, sw);
    wr(BASE + 8'd2, d, 0);
    watch(neff(nb), div + 1, msk, d, rbx(sw, neff(nb)), busy_at, rst_rise);
  endtask

  initial begin
    int dc, nr;
    logic [31:0] d1, d2, sw;
    repeat (3) @(negedge bus_clk);
    chk("reset_sen", sen, 8'hFF);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_mosi", mosi, 1'b0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_readback", readback, 32'h0);
    reset_global = 0;
    run(0, 8'h01, 24, 0, 0, 32'hABCDEF00, 32'h0, 0, 0);
    run(4, 8'h01, 12, 0, 0, 32'h12345678, 32'h5A3, 0, 0);
    run(1, 8'h01, 24, 0, 0, 32'h5A5A1234, $urandom, 20, 0);
    dc = 0; nr = 0;
    repeat (80) begin
      @(negedge bus_clk);
      if (done !== 1'b0) dc++;
      if (ready !== 1'b1) nr++;
    end
    chk("busy_one_done", dc, 0);
    chk("busy_ready_idle", nr, 0);
    run(2, 8'h02, 0, 0, 0, $urandom, $urandom, 0, 0);
    run(1, 8'h01, 24, 0, 0, 32'hC3C3C3C3, 32'h0, 0, 10);
    run(2, 8'h01, 24, 0, 0, 32'h0F1E2D3C, 32'h00A5B6C7, 0, 0);
    sw = $urandom; d1 = $urandom; d2 = $urandom;
    setup(2, 8'h10, 8, 0, 1, sw);
    wr(BASE + 8'd2, d1, 0);
    watch(8, 3, 8'h10, d1, rbx(sw, 8), 0, 0);
    sw = $urandom;
    slave(sw, 8, 1);
    wr(BASE + 8'd2, d2, 1);
    watch(8, 3, 8'h10, d2, rbx(sw, 8), 0, 0);
    for (int i = 0; i < 8; i++)
      run($urandom_range(2, 5), 8'($urandom_range(0, 255)), $urandom_range(0, 40),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/b200_spi_master.md
# b200_spi_master

Settings-bus-controlled SPI master that generates the shared `sclk`/`mosi`/`sen` bus for the AD9361 (slave 0) and ADF4001 (slave 1) on B2x0. The host writes divider, control and data registers through the settings bus. The block shifts one transfer of 1–32 bits MSB-first and returns the captured MISO word on `readback`. It sits directly upstream of the top-level SPI fan-out that gates `sclk`/`mosi` per chip select.

## Interface
- `BASE`, 8'd8: settings address of the divider register. Control is at `BASE+1`, data/trigger at `BASE+2`.
- `NUM_SEN`, 8: number of slave-select outputs.
- `CLKDIV_W`, 16: width of the clock divider.

Ports (clock and reset first):
- `bus_clk`  in  1  system clock, 100 MHz.
- `reset_global`  in  1  asynchronous, active-high reset.
- `set_stb`  in  1  settings write strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings write data.
- `ready`  out  1  high when idle and able to accept a trigger.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `readback`  out  32  last captured MISO bits, right-justified.
- `sen`  out  NUM_SEN  active-low slave selects.
- `sclk`  out  1  SPI clock; idles low (CPOL=0).
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; asynchronous to `bus_clk` on the board.

## Operation
- **Registers**:
  - `BASE+0` holds `clkdiv[CLKDIV_W-1:0]`.
  - `BASE+1` holds the control word:
    - [NUM_SEN-1:0] sen mask; 1 = assert that select.
    - [21:16] `nbits`; 0 or values >32 are treated as 32.
    - [24] `mosi_edge`: 0 = mosi changes on falling sclk; 1 = mosi changes on rising sclk.
    - [25] `miso_edge`: 0 = sample on rising sclk; 1 = sample on falling sclk.
  - `BASE+2` holds the data word. A write to it is the trigger.
- Register writes are accepted at any time. Divider and control values are latched into the working copy at the trigger, so writes during a transfer do not affect it.
- A trigger while `ready`=0 is ignored: no data latch, no queued transfer.
- TX data is left-justified. Bit `data[31]` is sent first, and `nbits` bits are sent in total.
- Half period H = `clkdiv`+1 `bus_clk` cycles.
- **States**:
  - IDLE: `sen`=all ones, `sclk`=0, `ready`=1. Trigger → ASSERT.
  - ASSERT: `sen`=~mask and `mosi`=`data[31]`. Lasts H cycles, then → SHIFT.
  - SHIFT: `sclk` toggles every H cycles for 2·`nbits` half periods.
    - `mosi` advances on the edge selected by `mosi_edge`. No advance occurs on the final edge.
    - MISO is sampled on the edge selected by `miso_edge`.
    - Ends with `sclk`=0 → DEASSERT.
  - DEASSERT: `sen` is held asserted for H cycles, then → DONE.
  - DONE: `sen`=all ones, `done`=1 for one cycle, `readback` updated, then → IDLE. `ready`=1 in the same cycle as `done`.
- `miso` passes through a 2-flop synchronizer before sampling. The sample point is the selected edge plus 2 cycles; this is acceptable for H≥3.
- **Readback**: captured bits are right-justified, with the first received bit in position `nbits`-1. Upper bits are zero. `readback` holds its value until the next DONE.
- **Reset**: asserting `reset_global` at any time, including mid-transfer, forces IDLE immediately. All registers clear to 0.

## Timing
- Reset values: `sen`=all ones, `sclk`=0, `mosi`=0, `ready`=1, `done`=0, `readback`=0; `clkdiv`=0, control=0, data=0.
- `ready` falls in the cycle after the trigger strobe.
- `done` is asserted exactly (2·`nbits`+2)·H+1 cycles after the trigger strobe cycle.
- A new trigger is accepted in the same cycle `done` is high. This gives back-to-back transfers with `sen` deasserted for a minimum of 1 cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `B200_SPI_MISO_CAPTURE_EN`:
  - Defined: the MISO synchronizer, capture shift register and `readback` logic are built.
  - Undefined: `readback` is tied to 32'h0 and `miso` is unused. All other timing is identical.

## Test plan
- Reset, then `clkdiv`=0, ctrl mask=8'h01 with `nbits`=24 and both edges 0, data=32'hABCDEF00 → `sen`=8'hFE for the transfer. `mosi` sequence = 0xABCDEF MSB-first, valid on 24 rising edges. `done` occurs 51 cycles after the trigger.
- With `B200_SPI_MISO_CAPTURE_EN` and `clkdiv`=4 (H=5), a slave model returns 0x5A3 over 12 bits → `readback`=32'h000005A3.
- Trigger issued while busy with data=32'hFFFFFFFF → ignored. The current `mosi` stream is unchanged and only one `done` pulse occurs.
- `nbits`=0 → exactly 32 sclk rising edges. `mask`=8'h02 → only `sen[1]` goes low.
- `reset_global` pulsed at sclk edge 10 of 24 → the cycle after reset, `sen`=8'hFF, `sclk`=0, `ready`=1, no `done`. A later trigger completes normally.
- Back-to-back triggers issued in the `done` cycles → two full transfers, with `sen` high for exactly 1 cycle between them.
